// File: rtl/fifo_pkg.sv
// Shared helpers for the RAM-backed FIFO controller: width derivation and
// parameter sanity checking.
package fifo_pkg;

  // Bits needed to hold an occupancy value in the range 0..depth inclusive.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Legal configuration: power-of-two depth of at least 4, and thresholds
  // ordered so that almost-empty and almost-full never describe the same level.
  function automatic bit params_ok(input int unsigned depth,
                                   input int unsigned ae_level,
                                   input int unsigned af_level);
    return (depth >= 4) &&
           ((depth & (depth - 1)) == 0) &&
           (ae_level < af_level) &&
           (af_level <= depth);
  endfunction

endpackage

// File: rtl/ram.sv
// Two-port RAM: synchronous write port, registered read port with one cycle
// of read latency. Contents are not reset.
module ram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     i_wr_clk,
  input  logic                     i_wr_dv,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_clk,
  input  logic                     i_rd_en,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]         o_rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: store the word when the write strobe is high.
  always_ff @(posedge i_wr_clk) begin
    if (i_wr_dv) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read port: register the addressed word, held when not enabled.
  always_ff @(posedge i_rd_clk) begin
    if (i_rd_en) begin
      o_rd_data <= mem[i_rd_addr];
    end
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Single-clock FIFO controller around the two-port RAM. Owns pointers,
// occupancy count and all status flags; flags are registered from the
// next-state count so they are exact in the cycle following each edge.
module ram_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_wr_en,
  input  logic [WIDTH-1:0]              i_wr_data,
  input  logic                          i_rd_en,
  output logic [WIDTH-1:0]              o_rd_data,
  output logic                          o_rd_dv,
  output logic                          o_full,
  output logic                          o_empty,
  output logic                          o_almost_full,
  output logic                          o_almost_empty,
  output logic [count_width(DEPTH)-1:0] o_count,
  output logic                          o_overflow,
  output logic                          o_underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = count_width(DEPTH);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  generate
    if (!params_ok(DEPTH, AE_LEVEL, AF_LEVEL)) begin : g_bad_params
      $error("ram_fifo_ctrl: DEPTH must be a power of two >= 4 with AE_LEVEL < AF_LEVEL <= DEPTH");
    end
  endgenerate

  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_nxt;
  logic          full_q;
  logic          empty_q;
  logic          push;
  logic          pop;

  // Acceptance uses registered flags only, so there is no fall-through.
  always_comb begin
    push = i_wr_en & ~full_q;
    pop  = i_rd_en & ~empty_q;
  end

  // Next occupancy: simultaneous push and pop leave it unchanged.
  always_comb begin
    count_nxt = count_q;
    case ({push, pop})
      2'b10:   count_nxt = count_q + CW'(1);
      2'b01:   count_nxt = count_q - CW'(1);
      default: count_nxt = count_q;
    endcase
  end

  // Pointer, count, flag and pulse registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      o_almost_full  <= 1'b0;
      o_almost_empty <= 1'b1;
      o_rd_dv        <= 1'b0;
      o_overflow     <= 1'b0;
      o_underflow    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q        <= count_nxt;
      full_q         <= (count_nxt == DEPTH_C);
      empty_q        <= (count_nxt == '0);
      o_almost_full  <= (count_nxt >= AF_C);
      o_almost_empty <= (count_nxt <= AE_C);
      o_rd_dv        <= pop;
      o_overflow     <= i_wr_en & full_q;
      o_underflow    <= i_rd_en & empty_q;
    end
  end

  // Expose internal state on the status ports.
  always_comb begin
    o_full  = full_q;
    o_empty = empty_q;
    o_count = count_q;
  end

  ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .i_wr_clk  (i_clk),
    .i_wr_dv   (push),
    .i_wr_addr (wr_ptr_q),
    .i_wr_data (i_wr_data),
    .i_rd_clk  (i_clk),
    .i_rd_en   (pop),
    .i_rd_addr (rd_ptr_q),
    .o_rd_data (o_rd_data)
  );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl: directed stimulus feeds a scoreboard
// of expected read words; a monitor compares them whenever o_rd_dv is high.
module tb_ram_fifo_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;

  logic             clk = 1'b0;
  logic             i_rst;
  logic             i_wr_en;
  logic [WIDTH-1:0] i_wr_data;
  logic             i_rd_en;
  logic [WIDTH-1:0] o_rd_data;
  logic             o_rd_dv;
  logic             o_full;
  logic             o_empty;
  logic             o_almost_full;
  logic             o_almost_empty;
  logic [4:0]       o_count;
  logic             o_overflow;
  logic             o_underflow;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  logic [WIDTH-1:0] sb_data [$];
  int unsigned      sb_cyc  [$];
  logic [WIDTH-1:0] mq      [$];

  ram_fifo_ctrl #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_wr_en        (i_wr_en),
    .i_wr_data      (i_wr_data),
    .i_rd_en        (i_rd_en),
    .o_rd_data      (o_rd_data),
    .o_rd_dv        (o_rd_dv),
    .o_full         (o_full),
    .o_empty        (o_empty),
    .o_almost_full  (o_almost_full),
    .o_almost_empty (o_almost_empty),
    .o_count        (o_count),
    .o_overflow     (o_overflow),
    .o_underflow    (o_underflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop the scoreboard on every valid read word, and flag words
  // that arrive unexpected, late, or not at all.
  always @(negedge clk) begin
    if (!i_rst) begin
      if (o_rd_dv) begin
        checks++;
        if (sb_data.size() == 0) begin
          errors++;
          $display("FAIL rd_dv_unexpected: got data 0x%0h with empty scoreboard (cycle %0d)", o_rd_data, cyc);
        end else begin
          automatic logic [WIDTH-1:0] exp_d = sb_data.pop_front();
          automatic int unsigned      exp_c = sb_cyc.pop_front();
          if (o_rd_data !== exp_d || exp_c != cyc) begin
            errors++;
            $display("FAIL rd_data: got 0x%0h at cycle %0d expected 0x%0h at cycle %0d",
                     o_rd_data, cyc, exp_d, exp_c);
          end
        end
      end else if (sb_cyc.size() != 0 && sb_cyc[0] <= cyc) begin
        checks++;
        errors++;
        $display("FAIL rd_dv_missing: got no data expected 0x%0h at cycle %0d", sb_data[0], sb_cyc[0]);
        void'(sb_data.pop_front());
        void'(sb_cyc.pop_front());
      end
    end
  end

  // One clock of stimulus; predicts which requests the FIFO accepts from
  // its occupancy before the edge, and queues the expected read word.
  task automatic cyc_op(input logic wr, input logic [WIDTH-1:0] d, input logic rd);
    automatic bit pop_ok  = rd && (mq.size() != 0);
    automatic bit push_ok = wr && (mq.size() != DEPTH);
    i_wr_en   = wr;
    i_wr_data = d;
    i_rd_en   = rd;
    if (pop_ok) begin
      sb_data.push_back(mq.pop_front());
      sb_cyc.push_back(cyc + 1);
    end
    if (push_ok) mq.push_back(d);
    @(posedge clk);
    #1;
    i_wr_en = 1'b0;
    i_rd_en = 1'b0;
  endtask

  initial begin
    i_rst     = 1'b1;
    i_wr_en   = 1'b0;
    i_wr_data = '0;
    i_rd_en   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;

    // Reset state after idling.
    repeat (5) cyc_op(1'b0, 8'h00, 1'b0);
    check("rst_empty", o_empty, 1);
    check("rst_full", o_full, 0);
    check("rst_count", o_count, 0);
    check("rst_dv", o_rd_dv, 0);
    check("rst_ae", o_almost_empty, 1);
    check("rst_af", o_almost_full, 0);
    check("rst_ovf", o_overflow, 0);
    check("rst_udf", o_underflow, 0);

    // Fill to full, watching almost-full and full thresholds.
    for (int i = 0; i < 16; i++) begin
      cyc_op(1'b1, 8'(i), 1'b0);
      check("fill_count", o_count, i + 1);
      check("fill_af", o_almost_full, (i + 1 >= 14) ? 1 : 0);
      check("fill_ae", o_almost_empty, (i + 1 <= 2) ? 1 : 0);
      check("fill_full", o_full, (i == 15) ? 1 : 0);
    end
    cyc_op(1'b1, 8'hFF, 1'b0);
    check("ovf_pulse", o_overflow, 1);
    check("ovf_count", o_count, 16);
    cyc_op(1'b0, 8'h00, 1'b0);
    check("ovf_one_cycle", o_overflow, 0);

    // Drain; data 0x00..0x0F checked by the monitor.
    for (int i = 0; i < 16; i++) cyc_op(1'b0, 8'h00, 1'b1);
    cyc_op(1'b0, 8'h00, 1'b0);
    check("drain_count", o_count, 0);
    check("drain_empty", o_empty, 1);

    // Pop while empty with concurrent push: no fall-through.
    cyc_op(1'b1, 8'hA5, 1'b1);
    check("udf_pulse", o_underflow, 1);
    check("udf_count", o_count, 1);
    check("udf_not_empty", o_empty, 0);
    cyc_op(1'b0, 8'h00, 1'b1);
    check("udf_one_cycle", o_underflow, 0);
    cyc_op(1'b0, 8'h00, 1'b0);
    check("a5_count", o_count, 0);

    // Half full, then streaming push/pop across several pointer wraps.
    for (int i = 0; i < 8; i++) cyc_op(1'b1, 8'(8'h10 + i), 1'b0);
    check("half_count", o_count, 8);
    for (int i = 0; i < 40; i++) begin
      cyc_op(1'b1, 8'(8'h40 + i), 1'b1);
      check("stream_count", o_count, 8);
    end
    for (int i = 0; i < 8; i++) cyc_op(1'b0, 8'h00, 1'b1);
    cyc_op(1'b0, 8'h00, 1'b0);
    check("stream_drained", o_count, 0);

    // Full with concurrent push/pop: pop accepted, push rejected.
    for (int i = 0; i < 16; i++) cyc_op(1'b1, 8'(8'h80 + i), 1'b0);
    check("full2_flag", o_full, 1);
    cyc_op(1'b1, 8'hEE, 1'b1);
    check("full_pp_ovf", o_overflow, 1);
    check("full_pp_count", o_count, 15);
    check("full_pp_udf", o_underflow, 0);
    check("full_pp_notfull", o_full, 0);
    for (int i = 0; i < 15; i++) cyc_op(1'b0, 8'h00, 1'b1);
    cyc_op(1'b0, 8'h00, 1'b0);
    check("full_pp_drained", o_count, 0);

    // Reset during an in-flight read word.
    cyc_op(1'b1, 8'h55, 1'b0);
    cyc_op(1'b1, 8'h66, 1'b0);
    cyc_op(1'b0, 8'h00, 1'b1);
    i_rst = 1'b1;
    sb_data.delete();
    sb_cyc.delete();
    mq.delete();
    #1;
    check("mid_rst_dv", o_rd_dv, 0);
    check("mid_rst_count", o_count, 0);
    check("mid_rst_empty", o_empty, 1);
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    cyc_op(1'b1, 8'h3C, 1'b0);
    check("post_rst_count", o_count, 1);
    cyc_op(1'b0, 8'h00, 1'b1);
    cyc_op(1'b0, 8'h00, 1'b0);
    check("post_rst_empty", o_empty, 1);

    repeat (2) cyc_op(1'b0, 8'h00, 1'b0);
    check("sb_drained", sb_data.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
Single-clock synchronous FIFO built around the team's two-port RAM block (registered read, one-cycle read latency). The block owns the write/read pointers, occupancy count and status flags, and sequences the RAM's write and read ports. It gives upstream producers and downstream consumers a flag-based push/pop interface. Both RAM clocks are tied to i_clk.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 16, number of entries; power of two, minimum 4
AF_LEVEL, DEPTH-2, o_almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 2, o_almost_empty asserts when count <= AE_LEVEL

Ports:
i_clk  input  1  single clock for all logic and both RAM ports
i_rst  input  1  asynchronous, active-high reset
i_wr_en  input  1  push request
i_wr_data  input  WIDTH  push data
i_rd_en  input  1  pop request
o_rd_data  output  WIDTH  popped data, valid when o_rd_dv=1
o_rd_dv  output  1  pop data valid, one cycle after an accepted pop
o_full  output  1  count == DEPTH
o_empty  output  1  count == 0
o_almost_full  output  1  count >= AF_LEVEL
o_almost_empty  output  1  count <= AE_LEVEL
o_count  output  $clog2(DEPTH+1)  current occupancy
o_overflow  output  1  one-cycle pulse: push rejected because full
o_underflow  output  1  one-cycle pulse: pop rejected because empty

Behaviour:
- Reset (asynchronous, active-high): wr_ptr=0, rd_ptr=0, count=0, o_empty=1, o_full=0, o_almost_empty=1, o_almost_full=0, o_rd_dv=0, o_overflow=0, o_underflow=0. o_rd_data is unspecified until the first o_rd_dv.
- Push accepted = i_wr_en & ~o_full. An accepted push writes i_wr_data to RAM[wr_ptr] at the clock edge, and wr_ptr increments.
- Pop accepted = i_rd_en & ~o_empty. An accepted pop presents rd_ptr to the RAM read port, and rd_ptr increments. o_rd_data and o_rd_dv are valid on the next cycle. Latency is exactly 1.
- Full/empty decisions use registered flags only. There is no fall-through: a pop while empty is rejected even if a push happens in the same cycle. A push while full is rejected even if a pop happens in the same cycle.
- Count update per cycle: +1 on push only, -1 on pop only, unchanged on both or neither. All flags are registered and derived from the next count, so they are accurate in the cycle after the edge.
- Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 naturally.
- Read and write addresses are never equal with both ports active, because equal pointers imply empty or full. No RAM collision handling is needed.
- o_overflow pulses on i_wr_en & o_full. o_underflow pulses on i_rd_en & o_empty. Both are registered and last one cycle. FIFO state is unchanged by a rejected request.
- Reset asserted mid-operation clears everything immediately, including an in-flight o_rd_dv. RAM contents are not cleared and are not observable.
- o_rd_dv is generated by this block's own reset-able register, not taken from the RAM.

Decomposition:
- fifo_pkg holds a function computing count width ($clog2(DEPTH+1)) and a localparam-check helper that asserts DEPTH is a power of two and that AE_LEVEL < AF_LEVEL <= DEPTH.
- One sub-module: an instance of RAM (WIDTH, DEPTH), with i_wr_clk=i_rd_clk=i_clk, i_wr_dv=push accepted, and i_rd_en=pop accepted.
- The pointer/count/flag logic is a single always_ff plus combinational next-state logic in ram_fifo_ctrl.

Test Plan:
- Reset, then idle 5 cycles -> o_empty=1, o_full=0, o_count=0, o_rd_dv=0, o_almost_empty=1.
- DEPTH=16: push 0x00..0x0F on consecutive cycles -> o_full=1 after the 16th push, o_almost_full from count 14. A 17th push gives o_overflow pulse, o_count stays 16. Then pop 16 times -> o_rd_data 0x00..0x0F in order, each 1 cycle after its pop, with o_rd_dv high.
- Pop while empty with a simultaneous push of 0xA5 -> o_underflow=1, no o_rd_dv, o_count=1. Next-cycle pop returns 0xA5.
- Half-full (8 entries), then simultaneous push/pop for 40 cycles -> o_count stays 8, data order preserved across 2+ pointer wraps.
- Full, then simultaneous push/pop -> pop accepted, push rejected with o_overflow, o_count=15.
- Assert i_rst in the cycle after a pop is accepted -> o_rd_dv=0 immediately, o_count=0, o_empty=1. Subsequent push 0x3C then pop returns 0x3C.
